mux_scan_sequencer: RTL

Scan controller that sits directly upstream of the 16-to-1 bit multiplexer. It drives the mux's 4-bit select, waits a programmable settle time, and samples the single-bit mux output for each enabled channel. It assembles the samples into a 16-bit snapshot word with a start/busy/done handshake, so downstream logic receives all 16 inputs as one parallel word instead of addressing the mux itself.

---
 rtl/mux_scan_if.sv | 22 ++
 rtl/mux_scan_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux_scan_if.sv
// Handshake and mux bundle between a scan requester and mux_scan_sequencer.
// The master drives start/mask and the mux output; the slave drives sel and results.
interface mux_scan_if;
  logic        start;
  logic [15:0] mask;
  logic        mux_out;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [4:0]  count;

  modport master (
    output start, mask, mux_out,
    input  sel, busy, done, result, count
  );

  modport slave (
    input  start, mask, mux_out,
    output sel, busy, done, result, count
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled channels of a 16:1 mux into one snapshot word.
// MUX_SCAN_CONTINUOUS_EN: a start seen at a completing edge chains the next scan.
module mux_scan_sequencer #(
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst,
  mux_scan_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam state_t     S_WAIT = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [3:0] LAST   = 4'(SETTLE - 1);

  state_t      r_state;
  logic [3:0]  r_sel;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic [4:0]  r_count;
  logic [3:0]  r_cnt;
  logic [15:0] r_mask;
  logic [15:0] r_shadow;

  state_t      w_state;
  logic [3:0]  w_sel;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_result;
  logic [4:0]  w_count;
  logic [3:0]  w_cnt;
  logic [15:0] w_mask;
  logic [15:0] w_shadow;
  logic        w_launch;
  logic [3:0]  w_first;
  logic [3:0]  w_next;
  logic        w_has_next;
  logic [4:0]  w_pop;

  always_comb begin
    w_first = '0;
    for (int i = 15; i >= 0; i--)
      if (bus.mask[i]) w_first = 4'(i);
  end

  always_comb begin
    w_next     = '0;
    w_has_next = 1'b0;
    for (int i = 15; i >= 0; i--)
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_next     = 4'(i);
        w_has_next = 1'b1;
      end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 16; i++)
      w_pop = w_pop + 5'(r_mask[i]);
  end

  always_comb begin
    w_state  = r_state;
    w_sel    = r_sel;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_result = r_result;
    w_count  = r_count;
    w_cnt    = r_cnt;
    w_mask   = r_mask;
    w_shadow = r_shadow;
    w_launch = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (|bus.mask) begin
            w_launch = 1'b1;
          end else begin
            w_done   = 1'b1;
            w_result = '0;
            w_count  = '0;
          end
        end
      end
      S_SETTLE: begin
        if (r_cnt == LAST) begin
          w_cnt   = '0;
          w_state = S_SAMPLE;
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
      S_SAMPLE: begin
        w_shadow[r_sel] = bus.mux_out;
        if (w_has_next) begin
          w_sel   = w_next;
          w_cnt   = '0;
          w_state = S_WAIT;
        end else begin
          w_result = w_shadow;
          w_count  = w_pop;
          w_done   = 1'b1;
          w_busy   = 1'b0;
          w_sel    = '0;
          w_state  = S_IDLE;
`ifdef MUX_SCAN_CONTINUOUS_EN
          w_launch = bus.start && (|bus.mask);
`endif
        end
      end
      default: w_state = S_IDLE;
    endcase
    // launch overrides the completion's idle values when chaining
    if (w_launch) begin
      w_mask   = bus.mask;
      w_sel    = w_first;
      w_busy   = 1'b1;
      w_shadow = '0;
      w_cnt    = '0;
      w_state  = S_WAIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state;
      r_sel    <= w_sel;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_result <= w_result;
      r_count  <= w_count;
      r_cnt    <= w_cnt;
      r_mask   <= w_mask;
      r_shadow <= w_shadow;
    end
  end

  assign bus.sel    = r_sel;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.count  = r_count;

endmodule
